fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of `asynchronous_fifo` among N requesters in the write clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's `w_en`/`data_in` directly. FIFO `full` backpressure is honoured. It sits between the write-side producers and the FIFO's write port, so no beat is ever lost or duplicated.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] index
);

  int j;

  // Scan from the farthest offset down so the nearest hit from ptr wins.
  always_comb begin
    any   = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        any   = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the write port of asynchronous_fifo.
// Optional per-requester beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                        wclk,
  input  logic                        wrst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        full,
  output logic                        w_en,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic [N_REQ*STAT_W-1:0]     beat_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_t    state, state_n;
  logic [IW-1:0] grant_n, ptr, ptr_n, grant_inc, pick_ptr, pick_idx;
  logic [CW-1:0] burst_ctr, ctr_n;
  logic          pick_any, beat, last_beat, release_g;

  assign busy      = (state == ARB_BURST);
  assign beat      = busy && req_valid[grant_id] && !full;
  assign w_en      = beat;
  assign data_in   = busy ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_inc = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign last_beat = beat && (burst_ctr == CW'(BURST_LEN - 1));
  assign release_g = busy && (last_beat || !req_valid[grant_id]);

  always_comb begin
    req_ready = '0;
    if (busy && !full) req_ready[grant_id] = 1'b1;
  end

  // During a burst the picker already looks from the post-release pointer,
  // so a handover needs no idle cycle.
  assign pick_ptr = busy ? grant_inc : ptr;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (pick_ptr),
    .any   (pick_any),
    .index (pick_idx)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= ARB_IDLE;
      grant_id  <= '0;
      ptr       <= '0;
      burst_ctr <= '0;
    end else begin
      state     <= state_n;
      grant_id  <= grant_n;
      ptr       <= ptr_n;
      burst_ctr <= ctr_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    ptr_n   = ptr;
    ctr_n   = burst_ctr;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_n = ARB_BURST;
          grant_n = pick_idx;
          ctr_n   = '0;
        end
      end
      ARB_BURST: begin
        if (release_g) begin
          ptr_n = grant_inc;
          ctr_n = '0;
          if (pick_any) grant_n = pick_idx;
          else          state_n = ARB_IDLE;
        end else if (beat) begin
          ctr_n = burst_ctr + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] cnt;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)                                                cnt[gi] <= '0;
      else if (beat && grant_id == IW'(gi) && cnt[gi] != '1)      cnt[gi] <= cnt[gi] + 1'b1;
    end
  end

  assign beat_cnt = cnt;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected beats, a monitor pops on w_en.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              wclk = 1'b0;
  logic              wrst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              full = 1'b0;
  logic              w_en;
  logic [DW-1:0]     data_in;
  logic [1:0]        grant_id;
  logic              busy;
  logic [N*16-1:0]   beat_cnt;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full(full), .w_en(w_en), .data_in(data_in),
    .grant_id(grant_id), .busy(busy), .beat_cnt(beat_cnt)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } beat_t;

  int         n_cmp = 0;
  int         n_err = 0;
  beat_t      expq[$];
  int         beat_cyc[$];
  int         cyc = 0;
  logic [N-1:0] en = '0;
  logic [7:0] base[N];
  int         pos[N];
  int         len[N];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (pos[i] < len[i]);
      req_data[i*DW +: DW] = base[i] + 8'(pos[i]);
    end
  endtask

  task automatic load(input int i, input logic [7:0] b, input int n);
    base[i] = b; pos[i] = 0; len[i] = n; en[i] = 1'b1;
    drive();
  endtask

  task automatic push(input int id, input logic [7:0] d, input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.id = 2'(id);
      e.d  = d + 8'(k);
      expq.push_back(e);
    end
  endtask

  // Requester i holds `total` beats; expected grant pattern is round-robin bursts of BL.
  task automatic push_rr(input int total);
    for (int r = 0; r * BL < total; r++)
      for (int i = 0; i < N; i++)
        push(i, 8'(i * 16 + r * BL), (total - r * BL < BL) ? total - r * BL : BL);
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge wclk);
    acc = req_valid & req_ready;
    if (full) begin
      chk("full_wen", int'(w_en), 0);
      chk("full_ready", int'(req_ready), 0);
    end
    @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) pos[i]++;
    drive();
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while ((expq.size() != 0 || req_valid != '0) && k < maxc) begin
      cycle();
      k++;
    end
    chk("timeout_left", expq.size() + int'(req_valid != '0), 0);
  endtask

  task automatic do_reset();
    full = 1'b0; en = '0;
    for (int i = 0; i < N; i++) begin pos[i] = 0; len[i] = 0; base[i] = '0; end
    drive();
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wen", int'(w_en), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_data", int'(data_in), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_cnt", int'(beat_cnt != '0), 0);
    @(posedge wclk);
    #3 wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    expq.delete();
    beat_cyc.delete();
  endtask

  // Monitor: every written beat must match the head of the expected queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge wclk);
      cyc++;
      if (wrst_n && w_en) begin
        beat_cyc.push_back(cyc);
        if (expq.size() == 0) chk("extra_beat", expq.size(), 1);
        else begin
          e = expq.pop_front();
          chk("beat_id", int'(grant_id), int'(e.id));
          chk("beat_data", int'(data_in), int'(e.d));
        end
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin pos[i] = 0; len[i] = 0; base[i] = '0; end
    #1;

    // 1: single requester, 4+2 split with no gap
    do_reset();
    push(2, 8'h10, 6);
    load(2, 8'h10, 6);
    wait_done(30);
    chk("s1_beats", beat_cyc.size(), 6);
    if (beat_cyc.size() == 6) chk("s1_gap", beat_cyc[5] - beat_cyc[0], 5);

    // 2: fairness, 0,1,2,3,0,... with 4-beat bursts
    do_reset();
    push_rr(8);
    for (int i = 0; i < N; i++) load(i, 8'(i * 16), 8);
    wait_done(60);
    chk("s2_beats", beat_cyc.size(), 32);

    // 3: backpressure at beat 2 of requester 1, requester 2 waiting
    do_reset();
    push(1, 8'h20, 4);
    push(2, 8'h30, 2);
    load(1, 8'h20, 4);
    load(2, 8'h30, 2);
    k = 0;
    while (pos[1] < 2 && k < 20) begin cycle(); k++; end
    chk("s3_reach", pos[1], 2);
    full = 1'b1;
    repeat (3) begin
      cycle();
      chk("s3_hold_grant", int'(grant_id), 1);
      chk("s3_hold_busy", int'(busy), 1);
    end
    full = 1'b0;
    wait_done(30);

    // 4: requester 0 withdraws after 2 beats, requester 3 takes over
    do_reset();
    push(0, 8'h40, 2);
    push(3, 8'h70, 2);
    load(0, 8'h40, 4);
    load(3, 8'h70, 2);
    k = 0;
    while (pos[0] < 2 && k < 20) begin cycle(); k++; end
    chk("s4_reach", pos[0], 2);
    en[0] = 1'b0;
    drive();
    cycle();
    chk("s4_grant", int'(grant_id), 3);
    chk("s4_busy", int'(busy), 1);
    chk("s4_ptr", int'(dut.ptr), 1);
    wait_done(30);

    // 5: reset mid-burst of requester 1, restart from requester 0
    do_reset();
    push(0, 8'h90, 1);
    load(0, 8'h90, 1);
    wait_done(20);
    push(1, 8'h50, 2);
    load(1, 8'h50, 4);
    k = 0;
    while (pos[1] < 2 && k < 20) begin cycle(); k++; end
    chk("s5_reach", pos[1], 2);
    #2 wrst_n = 1'b0;
    #1;
    chk("s5_wen", int'(w_en), 0);
    chk("s5_busy", int'(busy), 0);
    chk("s5_ready", int'(req_ready), 0);
    chk("s5_expq", expq.size(), 0);
    load(0, 8'h60, 1);
    #1 wrst_n = 1'b1;
    push(0, 8'h60, 1);
    push(1, 8'h52, 2);
    wait_done(30);

    // 6: statistics after 40 beats of full contention
    do_reset();
    push_rr(10);
    for (int i = 0; i < N; i++) load(i, 8'(i * 16), 10);
    wait_done(80);
    for (int i = 0; i < N; i++) begin
`ifdef FIFO_WR_ARB_STATS_EN
      chk("s6_cnt", int'(beat_cnt[i*16 +: 16]), 10);
`else
      chk("s6_cnt", int'(beat_cnt[i*16 +: 16]), 0);
`endif
    end

    repeat (3) @(posedge wclk);
    chk("final_expq", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
